// File: rtl/alu_operand_loader.sv
// Operand loader for the board ALU demo: debounces the load button and
// sequences switch values into Port A, Port B and the opcode.
//
// Ports:
//   CLK, RST        : clock, async active-high reset
//   sw_data/sw_fill : operand switches and upper-half fill select
//   load_btn        : raw active-high load button (asynchronous)
//   op_sel          : opcode switches
//   port_a/port_b   : latched operands
//   aluop           : latched opcode
//   operands_valid  : full operand set held, waiting for consume
//   consume         : downstream acknowledge (honoured only in VALID)
//   load_state      : encoded FSM state for the LEDs
module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] sw_data,
    input  logic        sw_fill,
    input  logic        load_btn,
    input  logic [3:0]  op_sel,
    output logic [31:0] port_a,
    output logic [31:0] port_b,
    output logic [3:0]  aluop,
    output logic        operands_valid,
    input  logic        consume,
    output logic [1:0]  load_state
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        VALID   = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             db_d;
    logic             db_prev_q;
    logic             load_pulse;

    state_e           state_q;
    state_e           state_d;
    logic [31:0]      port_a_q;
    logic [31:0]      port_a_d;
    logic [31:0]      port_b_q;
    logic [31:0]      port_b_d;
    logic [3:0]       aluop_q;
    logic [3:0]       aluop_d;
    logic             valid_q;
    logic             valid_d;
    logic [31:0]      fill;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= load_btn;
            sync2_q <= sync1_q;
        end
    end

    // The count runs only while the synchronized level disagrees with the
    // accepted level; any return to agreement restarts it, so short glitches
    // never reach the flip point.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q >= CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
        end
    end

    // One cycle high after each accepted press; release gives nothing.
    assign load_pulse = db_q & ~db_prev_q;

    assign fill = {{16{sw_fill}}, sw_data};

    always_comb begin
        state_d  = state_q;
        port_a_d = port_a_q;
        port_b_d = port_b_q;
        aluop_d  = aluop_q;
        valid_d  = valid_q;
        unique case (state_q)
            LOAD_A: begin
                if (load_pulse) begin
                    port_a_d = fill;
                    state_d  = LOAD_B;
                end
            end
            LOAD_B: begin
                if (load_pulse) begin
                    port_b_d = fill;
                    state_d  = LOAD_OP;
                end
            end
            LOAD_OP: begin
                if (load_pulse) begin
                    aluop_d = op_sel;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                // Pulses here are dropped, even one coinciding with consume.
                if (consume) begin
                    valid_d = 1'b0;
                    state_d = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= LOAD_A;
            port_a_q <= '0;
            port_b_q <= '0;
            aluop_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            port_a_q <= port_a_d;
            port_b_q <= port_b_d;
            aluop_q  <= aluop_d;
            valid_q  <= valid_d;
        end
    end

    assign port_a         = port_a_q;
    assign port_b         = port_b_q;
    assign aluop          = aluop_q;
    assign operands_valid = valid_q;
    assign load_state     = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a 4-cycle debounce.
// Expected values are hand-computed constants.
module tb_alu_operand_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] sw_data = '0;
    logic        sw_fill = 1'b0;
    logic        load_btn = 1'b0;
    logic [3:0]  op_sel = '0;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic [3:0]  aluop;
    logic        operands_valid;
    logic        consume = 1'b0;
    logic [1:0]  load_state;

    int n_cmp = 0;
    int n_err = 0;

    alu_operand_loader #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .sw_data(sw_data),
        .sw_fill(sw_fill),
        .load_btn(load_btn),
        .op_sel(op_sel),
        .port_a(port_a),
        .port_b(port_b),
        .aluop(aluop),
        .operands_valid(operands_valid),
        .consume(consume),
        .load_state(load_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic press(input int hold);
        @(negedge CLK);
        load_btn = 1'b1;
        repeat (hold) @(negedge CLK);
        load_btn = 1'b0;
        repeat (12) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        do_reset();
        check("rst_a", port_a, 32'h0);
        check("rst_b", port_b, 32'h0);
        check("rst_op", {28'h0, aluop}, 32'h0);
        check("rst_v", {31'h0, operands_valid}, 32'h0);
        check("rst_st", {30'h0, load_state}, 32'h0);

        // Too short to be accepted.
        sw_data = 16'hbeef;
        press(3);
        check("short_st", {30'h0, load_state}, 32'h0);
        check("short_a", port_a, 32'h0);

        sw_data = 16'h1234;
        sw_fill = 1'b0;
        press(10);
        check("clean_a", port_a, 32'h00001234);
        check("clean_st", {30'h0, load_state}, 32'h1);

        do_reset();
        sw_data = 16'h0005; sw_fill = 1'b1;
        press(10);
        sw_data = 16'h0003; sw_fill = 1'b0;
        press(10);
        op_sel = 4'h3;
        press(10);
        check("seq_a", port_a, 32'hffff0005);
        check("seq_b", port_b, 32'h00000003);
        check("seq_op", {28'h0, aluop}, 32'h3);
        check("seq_v", {31'h0, operands_valid}, 32'h1);
        check("seq_st", {30'h0, load_state}, 32'h3);

        // Press in VALID is ignored.
        sw_data = 16'h7777; op_sel = 4'h9;
        press(10);
        check("vpress_a", port_a, 32'hffff0005);
        check("vpress_op", {28'h0, aluop}, 32'h3);
        check("vpress_st", {30'h0, load_state}, 32'h3);

        @(negedge CLK);
        consume = 1'b1;
        @(negedge CLK);
        consume = 1'b0;
        check("cons_v", {31'h0, operands_valid}, 32'h0);
        check("cons_st", {30'h0, load_state}, 32'h0);
        check("cons_a", port_a, 32'hffff0005);
        check("cons_b", port_b, 32'h00000003);
        check("cons_op", {28'h0, aluop}, 32'h3);

        // consume in LOAD_A is ignored.
        @(negedge CLK);
        consume = 1'b1;
        @(negedge CLK);
        consume = 1'b0;
        check("cons_idle_st", {30'h0, load_state}, 32'h0);

        // Consume and load pulse in the same cycle.
        sw_data = 16'h00aa; sw_fill = 1'b0;
        press(10);
        sw_data = 16'h0001;
        press(10);
        op_sel = 4'h5;
        press(10);
        check("col_pre_st", {30'h0, load_state}, 32'h3);
        sw_data = 16'h5555;
        @(negedge CLK);
        load_btn = 1'b1;
        repeat (6) @(negedge CLK);
        consume = 1'b1;
        @(negedge CLK);
        consume = 1'b0;
        repeat (3) @(negedge CLK);
        load_btn = 1'b0;
        repeat (12) @(negedge CLK);
        check("col_st", {30'h0, load_state}, 32'h0);
        check("col_v", {31'h0, operands_valid}, 32'h0);
        check("col_a", port_a, 32'h000000aa);

        // Bounce, then stable high: capture on the 7th edge.
        sw_data = 16'h1234; sw_fill = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            load_btn = 1'b1;
            @(negedge CLK);
            @(negedge CLK);
            load_btn = 1'b0;
            @(negedge CLK);
        end
        check("bnc_quiet_a", port_a, 32'h000000aa);
        @(negedge CLK);
        load_btn = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        check("bnc_edge6_a", port_a, 32'h000000aa);
        @(posedge CLK);
        #1;
        check("bnc_edge7_a", port_a, 32'h00001234);
        repeat (5) @(negedge CLK);
        load_btn = 1'b0;
        repeat (12) @(negedge CLK);
        check("bnc_st", {30'h0, load_state}, 32'h1);

        // Async reset while in LOAD_OP.
        sw_data = 16'h0007;
        press(10);
        check("mid_st", {30'h0, load_state}, 32'h2);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("arst_a", port_a, 32'h0);
        check("arst_b", port_b, 32'h0);
        check("arst_st", {30'h0, load_state}, 32'h0);
        check("arst_v", {31'h0, operands_valid}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        sw_data = 16'h00ff; sw_fill = 1'b1;
        press(10);
        check("post_a", port_a, 32'hffff00ff);
        check("post_st", {30'h0, load_state}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
